opcode_sequencer: RTL and testbench

Synthesizable stimulus player that drives the `b12` game core's `k`, `start` and `__obs` inputs from a loadable opcode memory, one opcode per clock. It replaces the free-running behavioural program counter around the DUT with a controlled sequencer. The sequencer supports run, pause, abort, bounded or infinite repetition, and completion status, so concolic runs can be replayed, stepped and chained on-chip.

---
 rtl/opcode_sequencer.sv | 139 +++++++++++++
 tb/tb_opcode_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_sequencer.sv
// ============================================================================
// Module   : opcode_sequencer
// Brief    : Plays a loadable opcode memory onto the b12 core's k/start/obs
//            inputs, one opcode per clock, with pause, abort and repetition.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module opcode_sequencer #(
    parameter int DEPTH = 101,
    parameter int PCW   = 7,
    parameter int OPW   = 6
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           wr_en,
    input  logic [PCW-1:0] wr_addr,
    input  logic [OPW-1:0] wr_data,
    input  logic           run,
    input  logic [PCW-1:0] len,
    input  logic [7:0]     reps,
    input  logic           pause,
    input  logic           abort,
    output logic [3:0]     k,
    output logic           start,
    output logic           obs,
    output logic           step,
    output logic [PCW-1:0] pc,
    output logic           busy,
    output logic           done
);

    localparam logic [PCW-1:0] c_depth = PCW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state, w_state;
    logic [OPW-1:0] r_mem [DEPTH];
    logic [PCW-1:0] r_len, w_len;
    logic [7:0]     r_reps, w_reps;
    logic [7:0]     r_pass, w_pass;
    logic [PCW-1:0] w_pc;
    logic [OPW-1:0] w_op;
    logic [OPW-1:0] w_rd;
    logic           w_step;

    assign w_rd = (pc < c_depth) ? r_mem[pc] : '0;
    assign busy = (r_state == S_PLAY);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clock) begin
        if (!reset && !abort && wr_en && (r_state != S_PLAY) && (wr_addr < c_depth)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // pc == len marks "all passes issued"; the following unpaused edge enters
    // DONE, which also gives an empty program its single PLAY cycle.
    always_comb begin
        w_state = r_state;
        w_pc    = pc;
        w_op    = {obs, k, start};
        w_step  = 1'b0;
        w_len   = r_len;
        w_reps  = r_reps;
        w_pass  = r_pass;
        if (abort) begin
            w_state = S_IDLE;
            w_pc    = '0;
            w_op    = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (run) begin
                        w_len   = (len > c_depth) ? c_depth : len;
                        w_reps  = reps;
                        w_pc    = '0;
                        w_pass  = 8'd1;
                        w_op    = '0;
                        w_state = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (!pause) begin
                        if (pc == r_len) begin
                            w_state = S_DONE;
                            w_op    = '0;
                        end else begin
                            w_op   = w_rd;
                            w_step = 1'b1;
                            if ((pc == r_len - PCW'(1)) && ((r_reps == 8'd0) || (r_pass < r_reps))) begin
                                w_pc   = '0;
                                w_pass = (r_pass == 8'hFF) ? r_pass : r_pass + 8'd1;
                            end else begin
                                w_pc = pc + PCW'(1);
                            end
                        end
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_pc    = '0;
                    w_op    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            pc      <= '0;
            obs     <= 1'b0;
            k       <= 4'd0;
            start   <= 1'b0;
            step    <= 1'b0;
            r_len   <= '0;
            r_reps  <= 8'd0;
            r_pass  <= 8'd0;
        end else begin
            r_state <= w_state;
            pc      <= w_pc;
            obs     <= w_op[5];
            k       <= w_op[4:1];
            start   <= w_op[0];
            step    <= w_step;
            r_len   <= w_len;
            r_reps  <= w_reps;
            r_pass  <= w_pass;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_opcode_sequencer.sv
// ============================================================================
// Module   : tb_opcode_sequencer
// Brief    : Scoreboard bench for opcode_sequencer; expected issue/done events
//            are queued by the driver and checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_opcode_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [6:0] wr_addr = '0;
    logic [5:0] wr_data = '0;
    logic       run = 1'b0;
    logic [6:0] len = '0;
    logic [7:0] reps = '0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] k;
    logic       start, obs, step, busy, done;
    logic [6:0] pc;

    opcode_sequencer #(.DEPTH(101), .PCW(7), .OPW(6)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .run(run), .len(len), .reps(reps), .pause(pause),
        .abort(abort), .k(k), .start(start), .obs(obs), .step(step),
        .pc(pc), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         is_done;
        logic [5:0] op;
        int         pc;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    logic [5:0] model [101];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         prev_done = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every issued opcode and every DONE entry consumes one record.
    always @(negedge clock) begin
        exp_t e;
        bit   done_ev;
        done_ev = done && !prev_done;
        if (step || done_ev) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: step=%0b done=%0b pc=%0d cycle=%0d expected no event",
                         step, done, pc, cyc);
            end else begin
                e = q.pop_front();
                chk("ev_kind", longint'(done_ev), longint'(e.is_done));
                chk("ev_op", longint'({obs, k, start}), longint'(e.op));
                chk("ev_pc", longint'(pc), longint'(e.pc));
                chk("ev_cycle", longint'(cyc), longint'(e.cyc));
            end
        end
        prev_done = done;
    end

    task automatic push_ev(input bit d, input logic [5:0] op, input int p, input int c);
        exp_t e;
        e.is_done = d;
        e.op      = op;
        e.pc      = p;
        e.cyc     = c;
        q.push_back(e);
    endtask

    task automatic push_run(input int e0, input int l, input int r);
        int lq = (l > 101) ? 101 : l;
        int t  = e0;
        for (int p = 1; p <= r; p++) begin
            for (int i = 0; i < lq; i++) begin
                t++;
                push_ev(1'b0, model[i], ((i == lq - 1) && (p < r)) ? 0 : i + 1, t);
            end
        end
        push_ev(1'b1, 6'd0, lq, t + 1);
    endtask

    task automatic wr(input int a, input logic [5:0] d);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = 7'(a);
        wr_data = d;
        if (a < 101) model[a] = d;
    endtask

    task automatic start_run(input int l, input int r, input bit do_push, output int e0);
        @(negedge clock);
        run  = 1'b1;
        len  = 7'(l);
        reps = 8'(r);
        e0   = cyc + 1;
        if (do_push) push_run(e0, l, r);
        @(negedge clock);
        run = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, expected 1", done, limit);
        end
        @(negedge clock);
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_k"}, k, 0);
        chk({nm, "_start"}, start, 0);
        chk({nm, "_obs"}, obs, 0);
        chk({nm, "_step"}, step, 0);
        chk({nm, "_pc"}, pc, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
    endtask

    // Hand-decoded (obs,k,start) for the four test opcodes.
    logic [5:0] t1 [4];

    initial begin
        int e0;
        t1[0] = {1'b0, 4'd1, 1'b1};
        t1[1] = {1'b1, 4'd2, 1'b0};
        t1[2] = {1'b0, 4'd15, 1'b0};
        t1[3] = {1'b0, 4'd0, 1'b1};

        repeat (3) @(negedge clock);
        chk_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 101; i++) wr(i, 6'((i * 7 + 3) % 64));
        wr(0, 6'b000011);
        wr(1, 6'b100100);
        wr(2, 6'b011110);
        wr(3, 6'b000001);
        @(negedge clock);
        wr_en = 1'b0;

        // Single pass, hand-computed outputs
        start_run(4, 1, 1'b0, e0);
        for (int i = 0; i < 4; i++) push_ev(1'b0, t1[i], i + 1, e0 + 1 + i);
        push_ev(1'b1, 6'd0, 4, e0 + 5);
        wait_done(20);

        // Three contiguous passes, started from DONE
        start_run(4, 3, 1'b1, e0);
        wait_done(40);

        // Infinite repetition then abort
        start_run(2, 0, 1'b0, e0);
        for (int i = 1; i <= 300; i++) push_ev(1'b0, model[(i - 1) % 2], (i % 2 == 1) ? 1 : 0, e0 + i);
        repeat (300) @(negedge clock);
        chk("inf_busy", busy, 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk_zero("abort");
        chk("abort_queue", q.size(), 0);

        // Pause before E2..E4 delays DONE to E8
        start_run(4, 1, 1'b0, e0);
        push_ev(1'b0, model[0], 1, e0 + 1);
        push_ev(1'b0, model[1], 2, e0 + 5);
        push_ev(1'b0, model[2], 3, e0 + 6);
        push_ev(1'b0, model[3], 4, e0 + 7);
        push_ev(1'b1, 6'd0, 4, e0 + 8);
        @(negedge clock);
        pause = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("pause_step", step, 0);
            chk("pause_hold", {obs, k, start}, model[0]);
        end
        pause = 1'b0;
        wait_done(20);

        // Empty program and clamped length
        start_run(0, 1, 1'b1, e0);
        wait_done(10);
        start_run(127, 1, 1'b1, e0);
        wait_done(200);

        // Writes during PLAY are ignored
        start_run(4, 1, 1'b1, e0);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = 7'd1;
        wr_data = 6'h3F;
        @(negedge clock);
        wr_addr = 7'd2;
        @(negedge clock);
        wr_en = 1'b0;
        wait_done(20);
        start_run(4, 1, 1'b1, e0);
        wait_done(20);

        // Write in the same cycle as run is visible to playback
        @(negedge clock);
        run     = 1'b1;
        len     = 7'd4;
        reps    = 8'd1;
        wr_en   = 1'b1;
        wr_addr = 7'd2;
        wr_data = 6'b101010;
        model[2] = 6'b101010;
        e0 = cyc + 1;
        push_run(e0, 4, 1);
        @(negedge clock);
        run   = 1'b0;
        wr_en = 1'b0;
        wait_done(20);

        // Synchronous reset at E2, then replay
        start_run(4, 1, 1'b0, e0);
        push_ev(1'b0, model[0], 1, e0 + 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_zero("midreset");
        reset = 1'b0;
        chk("midreset_queue", q.size(), 0);
        start_run(4, 1, 1'b1, e0);
        wait_done(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, bad=%0d", bad);
        $fatal(1);
    end

endmodule

`default_nettype wire
